// File: rtl/sweeper_pkg.sv
// rtl/sweeper_pkg.sv - shared types and widths for the truth-table sweeper
// Contents: FSM state enum, vector/counter widths, last-vector helper.
package sweeper_pkg;

  localparam int VEC_W   = 4;
  localparam int NUM_VEC = 16;
  localparam int CNT_W   = 5;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    SAMPLE = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  function automatic logic is_last(input logic [VEC_W-1:0] v);
    return v == VEC_W'(NUM_VEC - 1);
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - link between the sweeper and the function under test
// Signals: vec (applied input vector {d,c,b,a}), f_pre / f_post (outputs A and B of the function).
// Modports: master = sweeper side (drives vec), slave = function side (drives f_pre/f_post).
interface truth_table_sweeper_if;
  import sweeper_pkg::*;

  logic [VEC_W-1:0] vec;
  logic             f_pre;
  logic             f_post;

  modport master (output vec, input f_pre, input f_post);
  modport slave  (input vec, output f_pre, output f_post);

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, debouncer and rising-edge pulse for one push button
// Ports: clk, rst_n (async active-low), btn_raw (raw button), btn_pulse (1-cycle pulse on debounced rise).
module btn_debounce #(
  parameter int DEB_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive cycles the synchronized input differs from the
  // accepted level; any return to the accepted level restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      level     <= 1'b0;
      cnt       <= '0;
      btn_pulse <= 1'b0;
    end else begin
      sync_1    <= btn_raw;
      sync_2    <= sync_1;
      btn_pulse <= 1'b0;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level     <= sync_2;
        cnt       <= '0;
        btn_pulse <= sync_2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks all 16 input vectors of a function and compares its two outputs
// Ports: clk, rst_n (async active-low), btn_start / btn_step (raw buttons), mode_auto (1 = timed),
//        fut (master side: vec out, f_pre / f_post in), busy, done, mismatch, err_cnt, first_bad.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int DWELL_CYC  = 50_000_000,
  parameter int DEB_CYC    = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     btn_start,
  input  logic                     btn_step,
  input  logic                     mode_auto,
  truth_table_sweeper_if.master    fut,
  output logic                     busy,
  output logic                     done,
  output logic                     mismatch,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [VEC_W-1:0]         first_bad
);

  // One timer serves both the settle and dwell intervals.
  localparam int TMR_MAX = (DWELL_CYC > SETTLE_CYC) ? DWELL_CYC : SETTLE_CYC;
  localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] DWELL_LAST  = TW'(DWELL_CYC - 1);

  logic start_p;
  logic step_p;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_start (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_start),
    .btn_pulse (start_p)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_step),
    .btn_pulse (step_p)
  );

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic             auto_q, auto_d;
  logic             busy_d, done_d, mismatch_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [VEC_W-1:0] first_bad_d;
  logic             leave_wait;
  logic             differ;

  assign fut.vec = vec_q;
  assign differ  = fut.f_pre ^ fut.f_post;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      vec_q     <= '0;
      auto_q    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
      err_cnt   <= '0;
      first_bad <= '0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      vec_q     <= vec_d;
      auto_q    <= auto_d;
      busy      <= busy_d;
      done      <= done_d;
      mismatch  <= mismatch_d;
      err_cnt   <= err_cnt_d;
      first_bad <= first_bad_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    vec_d       = vec_q;
    auto_d      = auto_q;
    busy_d      = busy;
    done_d      = done;
    mismatch_d  = mismatch;
    err_cnt_d   = err_cnt;
    first_bad_d = first_bad;
    leave_wait  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_p) begin
          auto_d      = mode_auto;
          err_cnt_d   = '0;
          first_bad_d = '0;
          mismatch_d  = 1'b0;
          done_d      = 1'b0;
          vec_d       = '0;
          busy_d      = 1'b1;
          tmr_d       = '0;
          state_d     = SETTLE;
        end
      end

      SETTLE: begin
        if (tmr_q == SETTLE_LAST) begin
          tmr_d   = '0;
          state_d = SAMPLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      SAMPLE: begin
        mismatch_d = differ;
        if (differ) begin
          // One increment per vector, so the count tops out at 16 on its own.
          err_cnt_d = err_cnt + CNT_W'(1);
          if (err_cnt == '0) first_bad_d = vec_q;
        end
        tmr_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // Dwell is measured from entry to WAIT; manual mode ignores the timer.
        if (auto_q) begin
          leave_wait = (tmr_q == DWELL_LAST);
          if (!leave_wait) tmr_d = tmr_q + TW'(1);
        end else begin
          leave_wait = step_p;
        end
        if (leave_wait) begin
          tmr_d = '0;
          if (is_last(vec_q)) begin
            state_d = DONE;
          end else begin
            vec_d   = vec_q + VEC_W'(1);
            state_d = SETTLE;
          end
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Drives the 4-bit input vector of a combinational function under test and reads back its two outputs, `f_pre` and `f_post`.
- Walks all 16 input combinations in order, auto-timed or one step per button press, and compares the two outputs at each vector.
- Reports the running mismatch count and the first failing vector on board LEDs.
- Sits on the EGO1 top level in place of the slide switches: it is the stimulus side of the pre/post circuits.

## Interface

Parameters:
- `SETTLE_CYC`, default 4: cycles from a vector change to the sample point; minimum 1.
- `DWELL_CYC`, default 50_000_000: cycles each vector is held in auto mode (0.5 s at 100 MHz); minimum 1.
- `DEB_CYC`, default 1_000_000: debounce stability window for buttons (10 ms); minimum 1.

Ports:
- `clk`, in, 1: 100 MHz board clock; the only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `btn_start`, in, 1: raw push button; starts a sweep.
- `btn_step`, in, 1: raw push button; advances one vector in manual mode.
- `mode_auto`, in, 1: 1 = auto-timed sweep, 0 = manual stepping; sampled only in IDLE.
- `f_pre`, in, 1: output A of the function under test.
- `f_post`, in, 1: output B of the function under test.
- `vec`, out, 4: applied vector, bit mapping {d,c,b,a} = vec[3:0].
- `busy`, out, 1: high while a sweep is in progress.
- `done`, out, 1: high after a full sweep, until the next start or reset.
- `mismatch`, out, 1: live compare at the last sample point, `f_pre ^ f_post`.
- `err_cnt`, out, 5: number of mismatching vectors, 0..16.
- `first_bad`, out, 4: lowest mismatching vector; valid only when `err_cnt` != 0.

## Operation

Reset (asynchronous, `rst_n` = 0):
- All outputs go to 0 immediately; FSM goes to IDLE; `vec` = 4'h0.

Button inputs:
- Each button passes through a 2-flop synchronizer, then a debouncer.
- Debouncer: the debounced level changes only after the raw level has been stable for `DEB_CYC` consecutive cycles.
- On a rising edge of the debounced level, the debouncer emits a single-cycle pulse: `start_p` or `step_p`.

FSM states:
- IDLE
  - On `start_p`: latch `mode_auto`, clear `err_cnt`, `first_bad`, `mismatch` and `done`, set `vec` = 0 and `busy` = 1, go to SETTLE.
- SETTLE
  - Count `SETTLE_CYC` cycles, then go to SAMPLE.
- SAMPLE (1 cycle)
  - `mismatch` <= `f_pre ^ f_post`.
  - If they differ: increment `err_cnt`. If `err_cnt` was 0, also load `first_bad` <= `vec`.
  - Go to WAIT.
- WAIT
  - Auto mode: stay `DWELL_CYC` cycles, counted from entry to WAIT.
  - Manual mode: stay until `step_p`.
  - Then, if `vec` == 15, go to DONE. Otherwise `vec` <= `vec` + 1 and go to SETTLE.
- DONE (1 cycle)
  - `busy` <= 0, `done` <= 1, `vec` holds 15, go to IDLE.

Boundary rules:
- `start_p` while `busy`: ignored.
- `step_p` outside manual-mode WAIT: ignored, not queued.
- `mode_auto` changes mid-sweep: no effect until the next start.
- `vec` never wraps inside a sweep. The 15→0 transition happens only via a new start.
- `err_cnt` saturates at 16 by construction (one increment per vector).
- `start_p` and `step_p` in the same cycle: `start_p` wins in IDLE, `step_p` wins in WAIT.
- Reset mid-sweep: immediate abort, all outputs 0, no partial results retained.

## Timing

- Vector change to sample point: exactly `SETTLE_CYC` + 1 cycles.
  - The change happens on the cycle `vec` is updated; the inputs are registered at the end of SAMPLE.
- Auto sweep length: 16 × (`SETTLE_CYC` + 1 + `DWELL_CYC`) cycles + 1, from the cycle after `start_p` to `done` rising.
- Debounce latency: 2 synchronizer cycles + `DEB_CYC` cycles from a stable raw edge to its pulse.
- All outputs are registered. `mismatch`, `err_cnt` and `first_bad` update only at the SAMPLE clock edge.

## Structure

- Package `sweeper_pkg` holds:
  - the FSM state enum (IDLE, SETTLE, SAMPLE, WAIT, DONE);
  - `VEC_W` = 4, `NUM_VEC` = 16, `CNT_W` = 5.
- Sub-module `btn_debounce`, parameter `DEB_CYC`; ports `clk`, `rst_n`, `btn_raw` → `btn_pulse`. It contains the synchronizer.
- Instantiated twice: one instance for start, one for step.
- The top level holds the FSM, the settle/dwell counter shared across states, and the result registers.

## Test plan

Bench parameters: `SETTLE_CYC`=2, `DWELL_CYC`=3, `DEB_CYC`=4.

- Auto sweep, equivalent functions:
  - Stimulus: `f_pre` = `f_post` = a&c | b&~c&d | a&~b&~c, computed from `vec`; press start.
  - Required: `vec` steps 0..15, `done` rises after 16×6+1 cycles, `err_cnt`=0, `busy`=0.
- Injected fault:
  - Stimulus: `f_post` forced to invert only at `vec` = 5 and `vec` = 11.
  - Required: `err_cnt`=2, `first_bad`=5, `mismatch`=1 after the SAMPLE for vector 11.
- Manual mode:
  - Stimulus: `mode_auto`=0; start; give 3 step presses.
  - Required: `vec`=3 and `busy`=1. After 13 more presses: `done`=1, `vec`=15. A 17th press changes nothing.
- Debounce:
  - Stimulus: step button toggled with 2-cycle pulses for 20 cycles, then held.
  - Required: exactly one advance.
  - Stimulus: start pressed mid-sweep.
  - Required: ignored, `vec` sequence unchanged.
- Reset mid-sweep:
  - Stimulus: assert `rst_n`=0 at `vec`=7 after one mismatch.
  - Required: all outputs 0 in the same cycle; a new start sweeps from 0 with `err_cnt` restarted.
- All-mismatch:
  - Stimulus: `f_post` = ~`f_pre`.
  - Required: `err_cnt`=16 with no wrap to 0, `first_bad`=0.
